// File: rtl/list_stream_if.sv
// Handshake/status bundle for list_stream: producer writes, consumer stream, and status.
// master drives the list's inputs; slave is the list itself.
interface list_stream_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              clear;
    logic              push;
    logic [WIDTH-1:0]  data_in;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              start;
    logic              mode;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  data_out;
    logic              out_last;
    logic              read_done;

    modport master (
        output clear, push, data_in, start, mode, out_ready,
        input  full, count, busy, out_valid, data_out, out_last, read_done
    );

    modport slave (
        input  clear, push, data_in, start, mode, out_ready,
        output full, count, busy, out_valid, data_out, out_last, read_done
    );
endinterface

// File: rtl/list_stream.sv
// Word list that buffers a burst and streams it back in LIFO or FIFO order on valid/ready.
// Define LIST_STREAM_POP_EN for destructive reads (count ends at 0 after every read).
module list_stream #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 256
) (
    input  logic         CLK,
    input  logic         RST,
    list_stream_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              mode_q, mode_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              mem_we;
    logic              full;
    logic [ADDR_W:0]   count_m1;
    logic [ADDR_W-1:0] first_ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    assign full      = (count_q == FULL_CNT);
    assign count_m1  = count_q - (ADDR_W + 1)'(1);
    assign first_ptr = bus.mode ? '0 : count_m1[ADDR_W-1:0];
    assign ptr_nxt   = mode_q ? ptr_q + ADDR_W'(1) : ptr_q - ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mem_we  = 1'b0;

        if (bus.clear) begin
            state_d = StIdle;
            count_d = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.push) begin
                        if (!full) begin
                            mem_we  = 1'b1;
                            count_d = count_q + (ADDR_W + 1)'(1);
                        end
                    end else if (bus.start) begin
                        mode_d = bus.mode;
                        if (count_q != '0) begin
                            ptr_d   = first_ptr;
                            data_d  = mem[first_ptr];
                            valid_d = 1'b1;
                            last_d  = (count_q == (ADDR_W + 1)'(1));
                            busy_d  = 1'b1;
                            state_d = StRead;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
                    end
                end
                StRead: begin
                    if (valid_q && bus.out_ready) begin
`ifdef LIST_STREAM_POP_EN
                        if (!mode_q) count_d = count_m1;
`endif
                        if (last_q) begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = StDone;
                        end else begin
                            // Terminal beat: index 0 going down, count-1 going up.
                            ptr_d  = ptr_nxt;
                            data_d = mem[ptr_nxt];
                            last_d = mode_q ? ({1'b0, ptr_nxt} == count_m1) : (ptr_nxt == '0);
                        end
                    end
                end
                StDone: begin
`ifdef LIST_STREAM_POP_EN
                    count_d = '0;
`endif
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[count_q[ADDR_W-1:0]] <= bus.data_in;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            count_q <= '0;
            ptr_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.full      = full;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.data_out  = data_q;
    assign bus.out_last  = last_q;
    assign bus.read_done = done_q;
endmodule

// File: tb/tb_list_stream.sv
// Directed bench for list_stream (WIDTH=4, DEPTH=4); expectations follow LIST_STREAM_POP_EN.
module tb_list_stream;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    list_stream_if #(.WIDTH(4), .DEPTH(4)) bus ();

    list_stream #(.WIDTH(4), .DEPTH(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results of the last run_read call.
    logic [3:0] beats [16];
    int         beat_cyc [16];
    logic [2:0] cnt_at [16];
    logic       full_at [16];
    int         nb, last_cnt, last_at, done_cnt, done_cyc, valid_cnt, hold_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] v);
        bus.push    = 1'b1;
        bus.data_in = v;
        tick();
        bus.push    = 1'b0;
    endtask

    task automatic clear_list();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    // Issue a start, then observe 16 cycles with out_ready following pat (bit per cycle).
    task automatic run_read(input logic m, input logic [15:0] pat);
        logic       stall;
        logic [3:0] held_d;
        logic       held_l;
        nb = 0; last_cnt = 0; last_at = -1; done_cnt = 0; done_cyc = -1;
        valid_cnt = 0; hold_err = 0; stall = 1'b0; held_d = '0; held_l = 1'b0;
        bus.mode  = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            bus.out_ready = pat[cyc];
            cnt_at[cyc]   = bus.count;
            full_at[cyc]  = bus.full;
            if (stall && (bus.out_valid !== 1'b1 || bus.data_out !== held_d ||
                          bus.out_last !== held_l)) hold_err++;
            stall = 1'b0;
            if (bus.out_valid === 1'b1) valid_cnt++;
            if (bus.read_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (nb < 16) begin
                    beats[nb]    = bus.data_out;
                    beat_cyc[nb] = cyc;
                end
                if (bus.out_last === 1'b1) begin
                    last_cnt++;
                    last_at = nb;
                end
                nb++;
            end else if (bus.out_valid === 1'b1) begin
                stall  = 1'b1;
                held_d = bus.data_out;
                held_l = bus.out_last;
            end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if ({bus.busy, bus.out_valid, bus.out_last, bus.read_done} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.out_valid, bus.out_last, bus.read_done}); end
        checks++; if (bus.data_out !== 4'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", bus.data_out); end
    endtask

    task automatic test_lifo();
        clear_list();
        push_word(4'd3); push_word(4'd1); push_word(4'd2);
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL lifo_fill_count got=%0d exp=3", bus.count); end
        run_read(1'b0, 16'hFFFF);
        checks++; if (nb !== 3) begin failures++; $display("FAIL lifo_beats got=%0d exp=3", nb); end
        checks++; if ({beats[0], beats[1], beats[2]} !== {4'd2, 4'd1, 4'd3}) begin
            failures++; $display("FAIL lifo_order got=%0d,%0d,%0d exp=2,1,3", beats[0], beats[1], beats[2]); end
        checks++; if (beat_cyc[0] !== 0 || beat_cyc[1] !== 1 || beat_cyc[2] !== 2) begin
            failures++; $display("FAIL lifo_timing got=%0d,%0d,%0d exp=0,1,2", beat_cyc[0], beat_cyc[1], beat_cyc[2]); end
        checks++; if (last_cnt !== 1 || last_at !== 2) begin
            failures++; $display("FAIL lifo_last got=%0d@%0d exp=1@2", last_cnt, last_at); end
        checks++; if (done_cnt !== 1 || done_cyc !== 3) begin
            failures++; $display("FAIL lifo_done got=%0d@%0d exp=1@3", done_cnt, done_cyc); end
`ifdef LIST_STREAM_POP_EN
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL lifo_count_after got=%0d exp=0", bus.count); end
`else
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL lifo_count_after got=%0d exp=3", bus.count); end
`endif
    endtask

    task automatic test_fifo_stall();
        clear_list();
        push_word(4'd3); push_word(4'd1); push_word(4'd2);
        run_read(1'b1, 16'b1111_1111_1111_0101);
        checks++; if (nb !== 3) begin failures++; $display("FAIL fifo_beats got=%0d exp=3", nb); end
        checks++; if ({beats[0], beats[1], beats[2]} !== {4'd3, 4'd1, 4'd2}) begin
            failures++; $display("FAIL fifo_order got=%0d,%0d,%0d exp=3,1,2", beats[0], beats[1], beats[2]); end
        checks++; if (beat_cyc[0] !== 0 || beat_cyc[1] !== 2 || beat_cyc[2] !== 4) begin
            failures++; $display("FAIL fifo_timing got=%0d,%0d,%0d exp=0,2,4", beat_cyc[0], beat_cyc[1], beat_cyc[2]); end
        checks++; if (hold_err !== 0 || valid_cnt !== 5) begin
            failures++; $display("FAIL fifo_hold got=err%0d/valid%0d exp=err0/valid5", hold_err, valid_cnt); end
        checks++; if (done_cnt !== 1 || done_cyc !== 5 || last_at !== 2) begin
            failures++; $display("FAIL fifo_done got=%0d@%0d last@%0d exp=1@5 last@2", done_cnt, done_cyc, last_at); end
    endtask

    task automatic test_full();
        clear_list();
        push_word(4'd1); push_word(4'd2); push_word(4'd3);
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL full_early got=%b exp=0", bus.full); end
        push_word(4'd4);
        checks++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
            failures++; $display("FAIL full_at4 got=%b/%0d exp=1/4", bus.full, bus.count); end
        push_word(4'd5);
        checks++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
            failures++; $display("FAIL full_overpush got=%b/%0d exp=1/4", bus.full, bus.count); end
        run_read(1'b0, 16'hFFFF);
        checks++; if (nb !== 4 || {beats[0], beats[1], beats[2], beats[3]} !== {4'd4, 4'd3, 4'd2, 4'd1}) begin
            failures++; $display("FAIL full_readout got=%0d beats %0d,%0d,%0d,%0d exp=4 beats 4,3,2,1",
                                 nb, beats[0], beats[1], beats[2], beats[3]); end
    endtask

    task automatic test_push_start();
        clear_list();
        bus.push = 1'b1; bus.start = 1'b1; bus.mode = 1'b0; bus.data_in = 4'd9;
        tick();
        bus.push = 1'b0; bus.start = 1'b0;
        checks++; if (bus.count !== 3'd1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL push_wins got=cnt%0d busy%b valid%b exp=cnt1 busy0 valid0",
                                 bus.count, bus.busy, bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.read_done !== 1'b0) begin
            failures++; $display("FAIL push_no_read got=valid%b done%b exp=0/0", bus.out_valid, bus.read_done); end
        clear_list();
        run_read(1'b0, 16'hFFFF);
        checks++; if (nb !== 0 || valid_cnt !== 0) begin
            failures++; $display("FAIL empty_read_beats got=%0d/%0d exp=0/0", nb, valid_cnt); end
        checks++; if (done_cnt !== 1 || done_cyc !== 0) begin
            failures++; $display("FAIL empty_read_done got=%0d@%0d exp=1@0", done_cnt, done_cyc); end
    endtask

    task automatic test_clear_mid();
        int seen_done;
        clear_list();
        push_word(4'd10); push_word(4'd11); push_word(4'd12); push_word(4'd13);
        bus.mode = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.out_ready = 1'b1;
        checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== 4'd10) begin
            failures++; $display("FAIL clr_beat1 got=%b/%0d exp=1/10", bus.out_valid, bus.data_out); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== 4'd11) begin
            failures++; $display("FAIL clr_beat2 got=%b/%0d exp=1/11", bus.out_valid, bus.data_out); end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0; bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL clr_abort got=valid%b cnt%0d busy%b exp=valid0 cnt0 busy0",
                                 bus.out_valid, bus.count, bus.busy); end
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.read_done === 1'b1) seen_done++;
            tick();
        end
        checks++; if (seen_done !== 0) begin failures++; $display("FAIL clr_no_done got=%0d exp=0", seen_done); end
        push_word(4'd7);
        run_read(1'b1, 16'hFFFF);
        checks++; if (nb !== 1 || beats[0] !== 4'd7 || done_cnt !== 1) begin
            failures++; $display("FAIL clr_recover got=%0d beat %0d done %0d exp=1 beat 7 done 1",
                                 nb, beats[0], done_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_list();
        push_word(4'd1); push_word(4'd2);
        bus.mode = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.out_valid, bus.busy, bus.out_last} !== 3'b000 || bus.count !== 3'd0 ||
                      bus.data_out !== 4'd0) begin
            failures++; $display("FAIL rstmid_async got=v%b b%b l%b cnt%0d d%0d exp=all 0",
                                 bus.out_valid, bus.busy, bus.out_last, bus.count, bus.data_out); end
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

`ifdef LIST_STREAM_POP_EN
    task automatic test_pop();
        clear_list();
        push_word(4'd1); push_word(4'd2); push_word(4'd3); push_word(4'd4);
        run_read(1'b0, 16'hFFFF);
        checks++; if ({cnt_at[0], cnt_at[1], cnt_at[2], cnt_at[3], cnt_at[4]} !==
                      {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin
            failures++; $display("FAIL pop_lifo_count got=%0d,%0d,%0d,%0d,%0d exp=4,3,2,1,0",
                                 cnt_at[0], cnt_at[1], cnt_at[2], cnt_at[3], cnt_at[4]); end
        checks++; if (full_at[0] !== 1'b1 || full_at[1] !== 1'b0) begin
            failures++; $display("FAIL pop_lifo_full got=%b,%b exp=1,0", full_at[0], full_at[1]); end
        clear_list();
        push_word(4'd5); push_word(4'd6);
        run_read(1'b1, 16'hFFFF);
        checks++; if (nb !== 2 || beats[0] !== 4'd5 || beats[1] !== 4'd6) begin
            failures++; $display("FAIL pop_fifo_beats got=%0d %0d,%0d exp=2 5,6", nb, beats[0], beats[1]); end
        checks++; if (cnt_at[2] !== 3'd2 || cnt_at[3] !== 3'd0 || bus.count !== 3'd0) begin
            failures++; $display("FAIL pop_fifo_count got=%0d,%0d,%0d exp=2,0,0", cnt_at[2], cnt_at[3], bus.count); end
    endtask
`endif

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.clear = 1'b0; bus.push = 1'b0; bus.data_in = '0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_lifo();
        test_fifo_stall();
        test_full();
        test_push_start();
        test_clear_mid();
        test_reset_mid();
`ifdef LIST_STREAM_POP_EN
        test_pop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
